// File: rtl/fp32_add_core_if.sv
// Operand and result channels of the fp32 adder: operands a and b are
// offered on separate stb/ack channels, result z on a stb/ack channel.
interface fp32_add_core_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] input_b;
  logic        input_b_stb;
  logic        input_b_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  // Driver side: offers operands, consumes the result.
  modport master (
    output input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    input  input_a_ack, input_b_ack, output_z, output_z_stb
  );

  // Core side: accepts operands, produces the result.
  modport slave (
    input  input_a, input_a_stb, input_b, input_b_stb, output_z_ack,
    output input_a_ack, input_b_ack, output_z, output_z_stb
  );
endinterface

// File: rtl/fp32_add_core.sv
// IEEE-754 single-precision adder, round-to-nearest-even, full denormal
// support. Operands arrive one after the other (a, then b); the result is
// held on output_z until acknowledged. Mantissas carry 3 extra low bits
// (guard, round, sticky) through align/add/normalize.
module fp32_add_core #(
  parameter int ALIGN_CLAMP = 27
) (
  input logic              clk,
  input logic              rst,
  fp32_add_core_if.slave   bus
);

  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, ALIGN, ADD_0, ADD_1,
    NORM_1, NORM_2, ROUND, PACK, PUT_Z
  } state_t;

  localparam logic signed [9:0] E_MIN = -10'sd126;
  localparam logic signed [9:0] E_MAX = 10'sd127;
  localparam logic signed [9:0] CLAMP = 10'(ALIGN_CLAMP);
  localparam logic [31:0]       QNAN  = 32'h7FC00000;

  state_t             state_reg, state_next;
  logic               a_ack_reg, a_ack_next;
  logic               b_ack_reg, b_ack_next;
  logic               z_stb_reg, z_stb_next;
  logic [31:0]        z_out_reg, z_out_next;
  logic [31:0]        a_reg, a_next;
  logic [31:0]        b_reg, b_next;
  logic [26:0]        a_m_reg, a_m_next;
  logic [26:0]        b_m_reg, b_m_next;
  logic signed [9:0]  a_e_reg, a_e_next;
  logic signed [9:0]  b_e_reg, b_e_next;
  logic               a_s_reg, a_s_next;
  logic               b_s_reg, b_s_next;
  logic [27:0]        sum_reg, sum_next;
  logic [26:0]        z_m_reg, z_m_next;
  logic signed [9:0]  z_e_reg, z_e_next;
  logic               z_s_reg, z_s_next;
  logic [31:0]        z_reg, z_next;

  // Scratch values used inside the next-state logic.
  logic signed [9:0]  diff;
  logic [9:0]         sh;
  logic [24:0]        inc;

  // Operand classes, taken straight from the captured encodings.
  logic a_nan, a_inf, a_zero, b_nan, b_inf, b_zero;
  assign a_nan  = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] != 23'd0);
  assign a_inf  = (a_reg[30:23] == 8'hFF) && (a_reg[22:0] == 23'd0);
  assign a_zero = (a_reg[30:0] == 31'd0);
  assign b_nan  = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] != 23'd0);
  assign b_inf  = (b_reg[30:23] == 8'hFF) && (b_reg[22:0] == 23'd0);
  assign b_zero = (b_reg[30:0] == 31'd0);

  assign bus.input_a_ack  = a_ack_reg;
  assign bus.input_b_ack  = b_ack_reg;
  assign bus.output_z     = z_out_reg;
  assign bus.output_z_stb = z_stb_reg;

  // Right shift by up to ALIGN_CLAMP; everything shifted past the sticky
  // position is OR-ed into the sticky bit.
  function automatic logic [26:0] align_shift(input logic [26:0] m, input logic [9:0] amt);
    logic [26+ALIGN_CLAMP:0] wide;
    wide = {m, {ALIGN_CLAMP{1'b0}}} >> amt;
    return {wide[26+ALIGN_CLAMP:ALIGN_CLAMP+1],
            wide[ALIGN_CLAMP] | (|wide[ALIGN_CLAMP-1:0])};
  endfunction

  // Next-state and datapath update for every state; defaults hold all registers.
  always_comb begin
    state_next = state_reg;
    a_ack_next = a_ack_reg;
    b_ack_next = b_ack_reg;
    z_stb_next = z_stb_reg;
    z_out_next = z_out_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    a_m_next   = a_m_reg;
    b_m_next   = b_m_reg;
    a_e_next   = a_e_reg;
    b_e_next   = b_e_reg;
    a_s_next   = a_s_reg;
    b_s_next   = b_s_reg;
    sum_next   = sum_reg;
    z_m_next   = z_m_reg;
    z_e_next   = z_e_reg;
    z_s_next   = z_s_reg;
    z_next     = z_reg;
    diff       = '0;
    sh         = '0;
    inc        = '0;

    case (state_reg)
      GET_A: begin
        if (!a_ack_reg) begin
          a_ack_next = 1'b1;
        end else if (bus.input_a_stb) begin
          a_next     = bus.input_a;
          a_ack_next = 1'b0;
          state_next = GET_B;
        end
      end

      GET_B: begin
        if (!b_ack_reg) begin
          b_ack_next = 1'b1;
        end else if (bus.input_b_stb) begin
          b_next     = bus.input_b;
          b_ack_next = 1'b0;
          state_next = UNPACK;
        end
      end

      UNPACK: begin
        a_m_next   = {(a_reg[30:23] != 8'd0), a_reg[22:0], 3'b000};
        b_m_next   = {(b_reg[30:23] != 8'd0), b_reg[22:0], 3'b000};
        a_e_next   = (a_reg[30:23] == 8'd0) ? E_MIN : $signed({2'b00, a_reg[30:23]}) - 10'sd127;
        b_e_next   = (b_reg[30:23] == 8'd0) ? E_MIN : $signed({2'b00, b_reg[30:23]}) - 10'sd127;
        a_s_next   = a_reg[31];
        b_s_next   = b_reg[31];
        state_next = SPECIAL;
      end

      SPECIAL: begin
        state_next = PUT_Z;
        if (a_nan || b_nan)                           z_next = QNAN;
        else if (a_inf && b_inf && (a_reg[31] != b_reg[31])) z_next = QNAN;
        else if (a_inf)                               z_next = {a_reg[31], 8'hFF, 23'd0};
        else if (b_inf)                               z_next = {b_reg[31], 8'hFF, 23'd0};
        else if (a_zero && b_zero)                    z_next = {a_reg[31] & b_reg[31], 31'd0};
        else if (a_zero)                              z_next = b_reg;
        else if (b_zero)                              z_next = a_reg;
        else                                          state_next = ALIGN;
      end

      ALIGN: begin
        if (a_e_reg > b_e_reg) begin
          diff     = a_e_reg - b_e_reg;
          sh       = (diff > CLAMP) ? CLAMP : diff;
          b_m_next = align_shift(b_m_reg, sh);
          b_e_next = a_e_reg;
        end else if (b_e_reg > a_e_reg) begin
          diff     = b_e_reg - a_e_reg;
          sh       = (diff > CLAMP) ? CLAMP : diff;
          a_m_next = align_shift(a_m_reg, sh);
          a_e_next = b_e_reg;
        end
        state_next = ADD_0;
      end

      ADD_0: begin
        z_e_next = a_e_reg;
        if (a_s_reg == b_s_reg) begin
          sum_next = {1'b0, a_m_reg} + {1'b0, b_m_reg};
          z_s_next = a_s_reg;
        end else if (a_m_reg > b_m_reg) begin
          sum_next = {1'b0, a_m_reg} - {1'b0, b_m_reg};
          z_s_next = a_s_reg;
        end else if (b_m_reg > a_m_reg) begin
          sum_next = {1'b0, b_m_reg} - {1'b0, a_m_reg};
          z_s_next = b_s_reg;
        end else begin
          // Exact cancellation always yields +0.
          sum_next = '0;
          z_s_next = 1'b0;
        end
        state_next = ADD_1;
      end

      ADD_1: begin
        if (sum_reg[27]) begin
          z_m_next = {sum_reg[27:2], sum_reg[1] | sum_reg[0]};
          z_e_next = z_e_reg + 10'sd1;
        end else begin
          z_m_next = sum_reg[26:0];
        end
        state_next = NORM_1;
      end

      NORM_1: begin
        // Sticky is kept on the left shift so round|sticky still reflects
        // the discarded tail after a single post-subtraction shift.
        if (!z_m_reg[26] && (z_e_reg > E_MIN)) begin
          z_m_next = {z_m_reg[25:0], z_m_reg[0]};
          z_e_next = z_e_reg - 10'sd1;
        end else begin
          state_next = NORM_2;
        end
      end

      NORM_2: begin
        if (z_e_reg < E_MIN) begin
          z_m_next = {1'b0, z_m_reg[26:2], z_m_reg[1] | z_m_reg[0]};
          z_e_next = z_e_reg + 10'sd1;
        end else begin
          state_next = ROUND;
        end
      end

      ROUND: begin
        if (z_m_reg[2] && (z_m_reg[1] || z_m_reg[0] || z_m_reg[3])) begin
          inc = {1'b0, z_m_reg[26:3]} + 25'd1;
          if (inc[24]) begin
            z_m_next[26:3] = 24'h800000;
            z_e_next       = z_e_reg + 10'sd1;
          end else begin
            z_m_next[26:3] = inc[23:0];
          end
        end
        state_next = PACK;
      end

      PACK: begin
        if (z_e_reg > E_MAX)
          z_next = {z_s_reg, 8'hFF, 23'd0};
        else if ((z_e_reg == E_MIN) && !z_m_reg[26])
          z_next = {z_s_reg, 8'h00, z_m_reg[25:3]};
        else
          z_next = {z_s_reg, z_e_reg[7:0] + 8'd127, z_m_reg[25:3]};
        state_next = PUT_Z;
      end

      PUT_Z: begin
        if (!z_stb_reg) begin
          z_stb_next = 1'b1;
          z_out_next = z_reg;
        end else if (bus.output_z_ack) begin
          z_stb_next = 1'b0;
          state_next = GET_A;
        end
      end

      default: state_next = GET_A;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight add.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= GET_A;
      a_ack_reg <= 1'b0;
      b_ack_reg <= 1'b0;
      z_stb_reg <= 1'b0;
      z_out_reg <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      a_m_reg   <= '0;
      b_m_reg   <= '0;
      a_e_reg   <= '0;
      b_e_reg   <= '0;
      a_s_reg   <= 1'b0;
      b_s_reg   <= 1'b0;
      sum_reg   <= '0;
      z_m_reg   <= '0;
      z_e_reg   <= '0;
      z_s_reg   <= 1'b0;
      z_reg     <= '0;
    end else begin
      state_reg <= state_next;
      a_ack_reg <= a_ack_next;
      b_ack_reg <= b_ack_next;
      z_stb_reg <= z_stb_next;
      z_out_reg <= z_out_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      a_m_reg   <= a_m_next;
      b_m_reg   <= b_m_next;
      a_e_reg   <= a_e_next;
      b_e_reg   <= b_e_next;
      a_s_reg   <= a_s_next;
      b_s_reg   <= b_s_next;
      sum_reg   <= sum_next;
      z_m_reg   <= z_m_next;
      z_e_reg   <= z_e_next;
      z_s_reg   <= z_s_next;
      z_reg     <= z_next;
    end
  end

endmodule

// File: tb/tb_fp32_add_core.sv
// Self-checking bench for fp32_add_core: directed vector table with
// latency checks, backpressure and mid-operation reset sequences, then
// randomized operands against an exact-arithmetic reference model.
module tb_fp32_add_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fp32_add_core_if bus();

  fp32_add_core #(.ALIGN_CLAMP(27)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  // Free-running posedge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
    int          lat;   // 0 means latency not checked
  } vec_t;

  typedef logic [299:0] big_t;

  logic [31:0] specials [6] = '{32'h00000000, 32'h80000000, 32'h7F800000,
                                32'hFF800000, 32'h7FC00000, 32'h7F800001};

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Exact reference: specials by priority, otherwise integer sum at the
  // finer exponent, then a single RNE rounding to 24 significant bits.
  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    logic sa, sb, s;
    logic [7:0] ea, eb;
    logic [22:0] fa, fb;
    logic an, ai, az, bn, bi, bz;
    int xa, xb, emin, p, e, k;
    big_t ma, mb, r, q, rem, half;
    sa = a[31]; ea = a[30:23]; fa = a[22:0];
    sb = b[31]; eb = b[30:23]; fb = b[22:0];
    an = (ea == 8'hFF) && (fa != 0); ai = (ea == 8'hFF) && (fa == 0); az = (ea == 0) && (fa == 0);
    bn = (eb == 8'hFF) && (fb != 0); bi = (eb == 8'hFF) && (fb == 0); bz = (eb == 0) && (fb == 0);
    if (an || bn) return 32'h7FC00000;
    if (ai && bi && (sa != sb)) return 32'h7FC00000;
    if (ai) return {sa, 8'hFF, 23'd0};
    if (bi) return {sb, 8'hFF, 23'd0};
    if (az && bz) return {sa & sb, 31'd0};
    if (az) return b;
    if (bz) return a;
    ma = '0; ma[23:0] = {ea != 8'd0, fa};
    mb = '0; mb[23:0] = {eb != 8'd0, fb};
    xa = (ea == 0) ? 1 : int'(ea);
    xb = (eb == 0) ? 1 : int'(eb);
    emin = (xa < xb) ? xa : xb;
    ma = ma << (xa - emin);
    mb = mb << (xb - emin);
    if (sa == sb)      begin r = ma + mb; s = sa; end
    else if (ma >= mb) begin r = ma - mb; s = sa; end
    else               begin r = mb - ma; s = sb; end
    if (r == 0) return 32'h00000000;
    p = 0;
    for (int i = 0; i < 300; i++) if (r[i]) p = i;
    e = emin + p - 23;
    if (e < 1) e = 1;
    k = e - emin;
    if (k <= 0) begin
      q = r << (-k);
    end else begin
      q = r >> k;
      rem = r & ((big_t'(1) << k) - 1);
      half = big_t'(1) << (k - 1);
      if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
    end
    if (q[24]) begin q = q >> 1; e++; end
    if (e >= 255) return {s, 8'hFF, 23'd0};
    if (!q[23]) return {s, 8'h00, q[22:0]};
    return {s, 8'(e), q[22:0]};
  endfunction

  // All handshake tasks are entered and left on a negedge.
  task automatic send_a(input logic [31:0] a);
    int n = 0;
    bus.input_a = a;
    bus.input_a_stb = 1'b1;
    while (bus.input_a_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("a_handshake");
    @(negedge clk);
    bus.input_a_stb = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] b, output int hs);
    int n = 0;
    bus.input_b = b;
    bus.input_b_stb = 1'b1;
    while (bus.input_b_ack !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) fail_now("b_handshake");
    hs = cyc + 1;
    @(negedge clk);
    bus.input_b_stb = 1'b0;
  endtask

  task automatic wait_z(input int hs, output logic [31:0] z, output int lat);
    int n = 0;
    while (bus.output_z_stb !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    if (n >= 400) begin
      fail_now("z_strobe");
      z = 32'hDEADBEEF;
      lat = -1;
    end else begin
      z = bus.output_z;
      lat = cyc - hs;
    end
  endtask

  task automatic gen_pair(output logic [31:0] a, output logic [31:0] b);
    int cat;
    logic [31:0] r1, r2;
    cat = $urandom_range(0, 5);
    r1 = $urandom;
    r2 = $urandom;
    a = r1;
    b = r2;
    case (cat)
      1: begin
        a[30:23] = 8'($urandom_range(1, 254));
        b[30:23] = a[30:23] + 8'($urandom_range(0, 3));
      end
      2: begin
        a = {r1[31], 8'd0, r1[22:0]};
        b = {r2[31], (r2[0] ? 8'd0 : 8'd1), r2[22:0]};
      end
      3: begin
        a[30:23] = 8'($urandom_range(1, 254));
        b = a ^ 32'h80000000;
        b[7:0] = r2[7:0];
      end
      4: begin
        a = specials[$urandom_range(0, 5)];
        if (r1[0]) begin b = a; a = r2; end
      end
      5: begin
        a[30:23] = 8'($urandom_range(40, 200));
        b[30:23] = a[30:23] - 8'($urandom_range(20, 32));
      end
      default: ;
    endcase
  endtask

  vec_t vecs [14];

  initial begin
    logic [31:0] z, ra, rb;
    int hs, lat;
    logic seen;

    vecs[0]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 10};
    vecs[1]  = '{32'h3F800000, 32'hBF800000, 32'h00000000, 0};
    vecs[2]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 3};
    vecs[3]  = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 3};
    vecs[4]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 10};
    vecs[5]  = '{32'h00000001, 32'h00000001, 32'h00000002, 10};
    vecs[6]  = '{32'h3F800000, 32'h33800000, 32'h3F800000, 10};
    vecs[7]  = '{32'h3F800001, 32'h33800000, 32'h3F800002, 10};
    vecs[8]  = '{32'h3FC00000, 32'hBF800000, 32'h3F000000, 11};
    vecs[9]  = '{32'h00000000, 32'hBF800000, 32'hBF800000, 3};
    vecs[10] = '{32'h80000000, 32'h80000000, 32'h80000000, 3};
    vecs[11] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 3};
    vecs[12] = '{32'h3F800000, 32'h5F000000, 32'h5F000000, 10};
    vecs[13] = '{32'h00800000, 32'h80000001, 32'h007FFFFF, 10};

    bus.input_a = '0;
    bus.input_a_stb = 1'b0;
    bus.input_b = '0;
    bus.input_b_stb = 1'b0;
    bus.output_z_ack = 1'b1;

    // Reset state, then input_a_ack one cycle after release.
    repeat (3) @(negedge clk);
    check32("rst_a_ack", {31'd0, bus.input_a_ack}, 32'd0);
    check32("rst_b_ack", {31'd0, bus.input_b_ack}, 32'd0);
    check32("rst_z_stb", {31'd0, bus.output_z_stb}, 32'd0);
    check32("rst_z", bus.output_z, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check32("a_ack_after_reset", {31'd0, bus.input_a_ack}, 32'd1);

    // Directed vectors.
    for (int i = 0; i < 14; i++) begin
      send_a(vecs[i].a);
      send_b(vecs[i].b, hs);
      wait_z(hs, z, lat);
      $display("vec %0d: %h + %h -> %h (latency %0d)", i, vecs[i].a, vecs[i].b, z, lat);
      check32($sformatf("vec%0d_z", i), z, vecs[i].z);
      if (vecs[i].lat != 0) check32($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
      @(negedge clk);
    end

    // Backpressure: result must hold for 5 cycles without ack.
    bus.output_z_ack = 1'b0;
    send_a(32'h40400000);
    send_b(32'h3F800000, hs);
    wait_z(hs, z, lat);
    $display("backpressure: 40400000 + 3f800000 -> %h", z);
    check32("bp_z_first", z, 32'h40800000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32($sformatf("bp_stb_%0d", i), {31'd0, bus.output_z_stb}, 32'd1);
      check32($sformatf("bp_z_%0d", i), bus.output_z, 32'h40800000);
    end
    bus.output_z_ack = 1'b1;
    @(negedge clk);
    check32("bp_stb_drop", {31'd0, bus.output_z_stb}, 32'd0);
    check32("bp_a_ack_low", {31'd0, bus.input_a_ack}, 32'd0);
    @(negedge clk);
    check32("bp_a_ack_rise", {31'd0, bus.input_a_ack}, 32'd1);

    // Reset two cycles after the b handshake abandons the add.
    send_a(32'h3F800000);
    send_b(32'h40000000, hs);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("mid-op reset applied at cycle %0d", cyc);
    check32("mid_rst_a_ack", {31'd0, bus.input_a_ack}, 32'd0);
    check32("mid_rst_b_ack", {31'd0, bus.input_b_ack}, 32'd0);
    check32("mid_rst_z_stb", {31'd0, bus.output_z_stb}, 32'd0);
    check32("mid_rst_z", bus.output_z, 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.output_z_stb === 1'b1) seen = 1'b1;
    end
    check32("no_z_after_reset", {31'd0, seen}, 32'd0);
    send_a(32'h40000000);
    send_b(32'h40000000, hs);
    wait_z(hs, z, lat);
    $display("post-reset: 40000000 + 40000000 -> %h", z);
    check32("post_reset_z", z, 32'h40800000);
    @(negedge clk);

    // Randomized operands against the reference model.
    for (int i = 0; i < 150; i++) begin
      gen_pair(ra, rb);
      send_a(ra);
      send_b(rb, hs);
      wait_z(hs, z, lat);
      $display("rand %0d: %h + %h -> %h (latency %0d)", i, ra, rb, z, lat);
      check32($sformatf("rand%0d", i), z, ref_add(ra, rb));
      @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Absolute time bound in case a handshake never completes.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached (%0d/%0d)", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
